// File: rtl/jedro_1_result_checker.sv
// End-of-test checker for jedro_1 benches: runs, drains, then scans the register file against a masked table.
// Optional JEDRO_1_CHECKER_XCHECK_EN: X/Z read data on a checked entry counts as a mismatch.
module jedro_1_result_checker #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int MAX_CYCLES   = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            start_i,
    input  logic                            illegal_instr_i,
    input  logic                            exp_we_i,
    input  logic [$clog2(NUM_REGS)-1:0]     exp_addr_i,
    input  logic [DATA_WIDTH-1:0]           exp_data_i,
    input  logic                            exp_clr_i,
    output logic [$clog2(NUM_REGS)-1:0]     chk_raddr_o,
    input  logic [DATA_WIDTH-1:0]           chk_rdata_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            pass_o,
    output logic                            timeout_o,
    output logic [$clog2(NUM_REGS+1)-1:0]   fail_count_o,
    output logic [$clog2(NUM_REGS)-1:0]     first_fail_o,
    output logic [$clog2(MAX_CYCLES+1)-1:0] cycles_o
);

    localparam int AW  = $clog2(NUM_REGS);
    localparam int FCW = $clog2(NUM_REGS + 1);
    localparam int CW  = $clog2(MAX_CYCLES + 1);
    localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cycles_q;
    logic [FCW-1:0]         fail_q;
    logic [AW-1:0]          first_q;
    logic                   timeout_q;
    logic [FCW-1:0]         idx_q;
    logic [DRW-1:0]         drain_q;
    logic                   mask_rd_q;
    logic [NUM_REGS-1:0]    mask_q;
    logic [NUM_REGS-1:0]    mask_d;
    logic [DATA_WIDTH-1:0]  exp_mem [NUM_REGS];
    logic [DATA_WIDTH-1:0]  exp_rd_q;

    logic                   tbl_en;
    logic                   rd_mismatch;
    logic [CW-1:0]          cycles_inc;
    logic [AW-1:0]          idx_lo;
    logic [AW-1:0]          idx_prev;
    logic                   scan_last;

    assign tbl_en     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign cycles_inc = cycles_q + CW'(1);
    assign idx_lo     = idx_q[AW-1:0];
    assign idx_prev   = idx_lo - AW'(1);
    assign scan_last  = (idx_q == FCW'(NUM_REGS));

    assign chk_raddr_o  = ((state_q == S_CHECK) && !scan_last) ? idx_lo : '0;
    assign busy_o       = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_CHECK);
    assign done_o       = (state_q == S_DONE);
    assign pass_o       = done_o && (fail_q == '0);
    assign timeout_o    = timeout_q;
    assign fail_count_o = fail_q;
    assign first_fail_o = first_q;
    assign cycles_o     = cycles_q;

`ifdef JEDRO_1_CHECKER_XCHECK_EN
    assign rd_mismatch = $isunknown(chk_rdata_i) || (chk_rdata_i != exp_rd_q);
`else
    assign rd_mismatch = (chk_rdata_i != exp_rd_q);
`endif

    // Clear has priority over a simultaneous write to the same table.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_mask
        assign mask_d[gi] = (tbl_en && exp_clr_i) ? 1'b0 :
                            (tbl_en && exp_we_i && (exp_addr_i == AW'(gi))) ? 1'b1 :
                            mask_q[gi];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    // Expected values live in a RAM; its registered read lines up with the register-file read latency.
    always_ff @(posedge clk_i) begin
        if (tbl_en && exp_we_i) begin
            exp_mem[exp_addr_i] <= exp_data_i;
        end
        exp_rd_q <= exp_mem[chk_raddr_o];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            cycles_q  <= '0;
            fail_q    <= '0;
            first_q   <= '0;
            timeout_q <= 1'b0;
            idx_q     <= '0;
            drain_q   <= '0;
            mask_rd_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q   <= S_RUN;
                        cycles_q  <= '0;
                        fail_q    <= '0;
                        first_q   <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    cycles_q <= cycles_inc;
                    if (illegal_instr_i || (cycles_inc == CW'(MAX_CYCLES))) begin
                        timeout_q <= !illegal_instr_i;
                        drain_q   <= '0;
                        idx_q     <= '0;
                        state_q   <= (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + DRW'(1);
                    if (drain_q == DRW'(DRAIN_CYCLES - 1)) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    mask_rd_q <= mask_q[chk_raddr_o];
                    // Slot k>0 judges entry k-1, whose read data arrives now.
                    if ((idx_q != '0) && mask_rd_q && rd_mismatch) begin
                        if (fail_q == '0) begin
                            first_q <= idx_prev;
                        end
                        if (fail_q != FCW'(NUM_REGS)) begin
                            fail_q <= fail_q + FCW'(1);
                        end
                    end
                    if (scan_last) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + FCW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_result_checker.sv
// Randomized scoreboard bench for jedro_1_result_checker with a behavioural table/register-file model.
module tb_jedro_1_result_checker;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int MC  = 32;
    localparam int DC  = 3;
    localparam int AW  = $clog2(NR);
    localparam int FCW = $clog2(NR + 1);
    localparam int CW  = $clog2(MC + 1);

    logic           clk = 1'b0;
    logic           rstn_i = 1'b0;
    logic           start_i = 1'b0;
    logic           illegal_i = 1'b0;
    logic           exp_we_i = 1'b0;
    logic [AW-1:0]  exp_addr_i = '0;
    logic [DW-1:0]  exp_data_i = '0;
    logic           exp_clr_i = 1'b0;
    logic [AW-1:0]  chk_raddr_o;
    logic [DW-1:0]  chk_rdata_i = '0;
    logic           busy_o, done_o, pass_o, timeout_o;
    logic [FCW-1:0] fail_count_o;
    logic [AW-1:0]  first_fail_o;
    logic [CW-1:0]  cycles_o;

    jedro_1_result_checker #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .MAX_CYCLES(MC), .DRAIN_CYCLES(DC)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .illegal_instr_i(illegal_i),
        .exp_we_i(exp_we_i), .exp_addr_i(exp_addr_i), .exp_data_i(exp_data_i),
        .exp_clr_i(exp_clr_i), .chk_raddr_o(chk_raddr_o), .chk_rdata_i(chk_rdata_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .fail_count_o(fail_count_o), .first_fail_o(first_fail_o), .cycles_o(cycles_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int to;
        int fc;
        int ff;
        int done_edge;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] exp_tab[NR];
    bit            mask_m[NR];
    logic [DW-1:0] rf[NR];
    int            checks = 0;
    int            errors = 0;
    int            edge_n = 0;
    int            txn = 0;
    bit            done_prev = 1'b0;

    always @(posedge clk) edge_n++;

    // Register file with one-cycle read latency.
    always @(posedge clk) chk_rdata_i <= rf[chk_raddr_o];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rstn_i) begin
            done_prev = 1'b0;
        end else begin
            if (done_o && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    txn++;
                    $display("txn %0d: cycles=%0d timeout=%0d fails=%0d first=%0d pass=%0d edge=%0d", txn,
                             cycles_o, timeout_o, fail_count_o, first_fail_o, pass_o, edge_n);
                    chk("cycles", int'(cycles_o), e.cyc);
                    chk("timeout", int'(timeout_o), e.to);
                    chk("fail_count", int'(fail_count_o), e.fc);
                    chk("first_fail", int'(first_fail_o), e.ff);
                    chk("pass", int'(pass_o), (e.fc == 0) ? 1 : 0);
                    chk("done_latency", edge_n, e.done_edge);
                end
            end
            done_prev = done_o;
        end
    end

    task automatic tbl_write(input int a, input logic [DW-1:0] d);
        exp_we_i = 1'b1; exp_addr_i = AW'(a); exp_data_i = d;
        @(posedge clk); #1;
        exp_we_i = 1'b0;
        exp_tab[a] = d; mask_m[a] = 1'b1;
    endtask

    task automatic tbl_clr(input bit with_write);
        exp_clr_i = 1'b1; exp_we_i = with_write; exp_addr_i = AW'($urandom_range(0, NR - 1));
        exp_data_i = $urandom;
        @(posedge clk); #1;
        exp_clr_i = 1'b0; exp_we_i = 1'b0;
        for (int r = 0; r < NR; r++) mask_m[r] = 1'b0;
    endtask

    task automatic rand_rf();
        for (int r = 0; r < NR; r++)
            rf[r] = (mask_m[r] && $urandom_range(0, 3) != 0) ? exp_tab[r] : DW'($urandom);
    endtask

    task automatic run_test(input int ill_at);
        exp_t e;
        bit   seen;
        bit   ends_illegal;
        ends_illegal = (ill_at >= 1) && (ill_at <= MC);
        e.cyc = ends_illegal ? ill_at : MC;
        e.to  = ends_illegal ? 0 : 1;
        e.fc  = 0;
        e.ff  = 0;
        for (int r = 0; r < NR; r++) begin
            if (mask_m[r] && (rf[r] !== exp_tab[r])) begin
                if (e.fc == 0) e.ff = r;
                e.fc++;
            end
        end
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        e.done_edge = edge_n + e.cyc + DC + NR + 1;
        sb.push_back(e);
        chk("start_clear", int'({busy_o, done_o, timeout_o, fail_count_o, first_fail_o, cycles_o}),
            1 << (2 + FCW + AW + CW));
        seen = 1'b0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            illegal_i = (ill_at >= 1) && (c >= ill_at);
            start_i   = (c == 2);
            @(posedge clk); #1;
            seen = done_o;
        end
        illegal_i = 1'b0;
        start_i   = 1'b0;
        if (!seen) begin
            chk("done_wait", int'(done_o), 1);
            void'(sb.pop_back());
        end
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            exp_tab[r] = '0; mask_m[r] = 1'b0; rf[r] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({busy_o, done_o, pass_o, timeout_o, fail_count_o, first_fail_o, cycles_o, chk_raddr_o}), 0);
        rstn_i = 1'b1;
        @(posedge clk); #1;

        // Single register pass
        tbl_write(7, 32'd15);
        rand_rf(); rf[7] = 32'd15;
        run_test(10);

        // Two mismatches
        tbl_clr(1'b0);
        tbl_write(7, 32'd15);
        tbl_write(9, 32'hFFFF_FFFF);
        rand_rf(); rf[7] = 32'd14; rf[9] = 32'd0;
        run_test(11);

        // Timeout, plus illegal exactly on the limit cycle
        run_test(0);
        run_test(MC);

        // Mask handling
        tbl_write(3, 32'd5);
        tbl_clr(1'b0);
        tbl_write(4, 32'd1);
        rand_rf(); rf[3] = 32'd0; rf[4] = 32'd1;
        run_test(6);

        // Clear wins over a simultaneous write
        tbl_clr(1'b1);
        rand_rf();
        run_test(1);

`ifdef JEDRO_1_CHECKER_XCHECK_EN
        tbl_clr(1'b0);
        tbl_write(7, 32'd15);
        rand_rf(); rf[7] = 'x;
        run_test(4);
`endif

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 3) == 0) tbl_clr($urandom_range(0, 1) == 1);
            for (int w = $urandom_range(0, 5); w > 0; w--)
                tbl_write($urandom_range(0, NR - 1), DW'($urandom));
            rand_rf();
            run_test($urandom_range(1, 45));
        end

        // Reset in the middle of the scan
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1; illegal_i = 1'b1;
        @(posedge clk); #1; illegal_i = 1'b0;
        repeat (DC + 10) @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(busy_o), 1);
        rstn_i = 1'b0;
        #1;
        chk("mid_check_reset", int'({busy_o, done_o, pass_o, timeout_o, fail_count_o, first_fail_o, cycles_o, chk_raddr_o}), 0);
        for (int r = 0; r < NR; r++) mask_m[r] = 1'b0;
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(posedge clk); #1;

        // Empty mask must still pass after a full scan
        rand_rf();
        run_test(5);
        tbl_write(12, 32'hA5A5_0001);
        rand_rf(); rf[12] = 32'h0;
        run_test(8);
        run_test(3);

        @(posedge clk); #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
